// File: rtl/multi_cycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: opcodes, FSM
// state encoding, ALU operation and ALU operand-B select codes.
package multi_cycle_control_unit_pkg;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_ARITH_R = 7'b0110011;
  localparam logic [6:0] OPC_ARITH_I = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  function automatic logic is_arith(input logic [6:0] opc);
    return (opc == OPC_ARITH_R) || (opc == OPC_ARITH_I);
  endfunction

endpackage

// File: rtl/multi_cycle_control_unit_mem_wait_counter.sv
// Memory-latency wait counter shared by the fetch and memory states; counts
// 0..MEM_LATENCY-1 while start is high and flags the final cycle.
module mem_wait_counter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic clk,
  input  logic start,
  input  logic clear,
  output logic last
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_LATENCY - 1);

  logic [CNT_W-1:0] count_r;

  assign last = (count_r == CNT_MAX);

  // Advance while a wait state is active; return to zero on the last cycle or when idle.
  always_ff @(posedge clk) begin
    if (clear) begin
      count_r <= '0;
    end else if (start && !last) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= '0;
    end
  end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32I sequencing FSM (IF/ID/EX/MEM/WB/HALT) driving the shared
// ALU/memory datapath. Optional ECALL halt: define MULTI_CYCLE_ECALL_HALT_EN.
module multi_cycle_control_unit
  import multi_cycle_control_unit_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ALU_OP_W    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          part_of_inst,
  input  logic                bcond,
  input  logic                ecall_x17_is_10,
  output logic                pc_write,
  output logic                pc_source,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                pc_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                is_halted
);

  state_t     state_r;
  state_t     next_s;
  logic       wait_last_s;
  logic       wait_start_s;
  logic       halt_take_s;
  logic [1:0] alu_op_s;

  assign wait_start_s = (state_r == S_IF) || (state_r == S_MEM);

  mem_wait_counter #(.MEM_LATENCY(MEM_LATENCY)) u_wait (
    .clk   (clk),
    .start (wait_start_s),
    .clear (reset),
    .last  (wait_last_s)
  );

`ifdef MULTI_CYCLE_ECALL_HALT_EN
  logic is_halted_r;

  assign halt_take_s = ecall_x17_is_10;
  assign is_halted   = is_halted_r;

  // Sticky halt flag, set together with the transition into HALT.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_halted_r <= 1'b0;
    end else if (next_s == S_HALT) begin
      is_halted_r <= 1'b1;
    end else begin
      is_halted_r <= is_halted_r;
    end
  end
`else
  logic unused_ecall_s;

  assign unused_ecall_s = ecall_x17_is_10;
  assign halt_take_s    = 1'b0;
  assign is_halted      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IF;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state and strobe decode from the current state and opcode.
  always_comb begin
    next_s     = state_r;
    pc_write   = 1'b0;
    pc_source  = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_to_reg  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_RS2;
    alu_op_s   = ALU_OP_ADD;
    case (state_r)
      S_IF: begin
        mem_read = 1'b1;
        if (wait_last_s) begin
          ir_write = 1'b1;
          next_s   = S_ID;
        end else begin
          next_s   = S_IF;
        end
      end
      S_ID: begin
        alu_src_b = SRC_B_IMM;
        if (part_of_inst == OPC_JAL) begin
          next_s = S_WB;
        end else if (part_of_inst == OPC_SYSTEM) begin
          next_s = halt_take_s ? S_HALT : S_WB;
        end else begin
          next_s = S_EX;
        end
      end
      S_EX: begin
        alu_src_a = 1'b1;
        next_s    = S_WB;
        case (part_of_inst)
          OPC_ARITH_R: alu_op_s = ALU_OP_FUNCT;
          OPC_ARITH_I: begin
            alu_src_b = SRC_B_IMM;
            alu_op_s  = ALU_OP_FUNCT;
          end
          OPC_LOAD, OPC_STORE: begin
            alu_src_b = SRC_B_IMM;
            next_s    = S_MEM;
          end
          OPC_JALR: alu_src_b = SRC_B_IMM;
          OPC_BRANCH: begin
            alu_op_s = ALU_OP_BRANCH;
            if (bcond) begin
              pc_write  = 1'b1;
              pc_source = 1'b1;
              next_s    = S_IF;
            end else begin
              next_s    = S_WB;
            end
          end
          default: next_s = S_WB;
        endcase
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = (part_of_inst == OPC_LOAD);
        mem_write = (part_of_inst == OPC_STORE);
        next_s    = wait_last_s ? S_WB : S_MEM;
      end
      S_WB: begin
        alu_src_b  = SRC_B_FOUR;
        pc_write   = 1'b1;
        pc_source  = (part_of_inst == OPC_JAL) || (part_of_inst == OPC_JALR);
        pc_to_reg  = (part_of_inst == OPC_JAL) || (part_of_inst == OPC_JALR);
        mem_to_reg = (part_of_inst == OPC_LOAD);
        reg_write  = (part_of_inst == OPC_LOAD) || is_arith(part_of_inst) ||
                     (part_of_inst == OPC_JAL) || (part_of_inst == OPC_JALR);
        next_s     = S_IF;
      end
      S_HALT: next_s = S_HALT;
      default: next_s = S_IF;
    endcase
    if (reset) begin
      pc_write   = 1'b0;
      pc_source  = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      pc_to_reg  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRC_B_RS2;
      alu_op_s   = ALU_OP_ADD;
    end else begin
      alu_op_s   = alu_op_s;
    end
  end

  assign alu_op = ALU_OP_W'(alu_op_s);

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Self-checking bench: two instances (latency 1 and 3) exercised in turn
// against a cycle-count / strobe-tally model of each instruction class.
module tb_multi_cycle_control_unit;

  localparam logic [6:0] T_LOAD = 7'b0000011, T_STORE = 7'b0100011, T_BR = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111, T_JALR = 7'b1100111, T_R = 7'b0110011;
  localparam logic [6:0] T_I = 7'b0010011, T_SYS = 7'b1110011, T_LUI = 7'b0110111;

  // bundle bit positions
  localparam int PCW = 14, PCS = 13, IORD = 12, MR = 11, MW = 10, IRW = 9, RW = 8;
  localparam int M2R = 7, P2R = 6, H = 0;

  logic clk = 1'b0;
  logic reset1, reset3, bcond, ecall_x17_is_10, sel;
  logic [6:0] part_of_inst;
  int n_vec = 0, n_err = 0;

  logic pcw1, pcs1, iord1, mr1, mw1, irw1, rw1, m2r1, p2r1, sa1, h1;
  logic pcw3, pcs3, iord3, mr3, mw3, irw3, rw3, m2r3, p2r3, sa3, h3;
  logic [1:0] sb1, op1, sb3, op3;
  logic [14:0] b1, b3, cur;

  always #5 clk = ~clk;

  multi_cycle_control_unit #(.MEM_LATENCY(1), .ALU_OP_W(2)) dut1 (
    .clk(clk), .reset(reset1), .part_of_inst(part_of_inst), .bcond(bcond),
    .ecall_x17_is_10(ecall_x17_is_10), .pc_write(pcw1), .pc_source(pcs1),
    .i_or_d(iord1), .mem_read(mr1), .mem_write(mw1), .ir_write(irw1),
    .reg_write(rw1), .mem_to_reg(m2r1), .pc_to_reg(p2r1), .alu_src_a(sa1),
    .alu_src_b(sb1), .alu_op(op1), .is_halted(h1));

  multi_cycle_control_unit #(.MEM_LATENCY(3), .ALU_OP_W(2)) dut3 (
    .clk(clk), .reset(reset3), .part_of_inst(part_of_inst), .bcond(bcond),
    .ecall_x17_is_10(ecall_x17_is_10), .pc_write(pcw3), .pc_source(pcs3),
    .i_or_d(iord3), .mem_read(mr3), .mem_write(mw3), .ir_write(irw3),
    .reg_write(rw3), .mem_to_reg(m2r3), .pc_to_reg(p2r3), .alu_src_a(sa3),
    .alu_src_b(sb3), .alu_op(op3), .is_halted(h3));

  assign b1  = {pcw1, pcs1, iord1, mr1, mw1, irw1, rw1, m2r1, p2r1, sa1, sb1, op1, h1};
  assign b3  = {pcw3, pcs3, iord3, mr3, mw3, irw3, rw3, m2r3, p2r3, sa3, sb3, op3, h3};
  assign cur = sel ? b3 : b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (latency %0d)", tag, obs, exp, sel ? 3 : 1);
    end
  endtask

  task automatic set_reset(input logic v);
    if (sel) reset3 = v;
    else reset1 = v;
  endtask

  // Holds reset across one edge, then releases it: the caller continues in fetch cycle 0.
  task automatic do_reset();
    set_reset(1'b1);
    #1 check("rst_strobes", 32'(cur[14:1]), 32'd0);
    @(negedge clk);
    #1 check("rst_state", 32'(cur), 32'd0);
    set_reset(1'b0);
  endtask

  function automatic logic [6:0] pick(input int r);
    case (r)
      0: return T_R;
      1: return T_I;
      2: return T_LOAD;
      3: return T_STORE;
      4: return T_BR;
      5: return T_JAL;
      6: return T_JALR;
      7: return T_SYS;
      default: return T_LUI;
    endcase
  endfunction

  // force_bc: 0 random bcond each cycle, 1 always 1, 2 always 0.
  task automatic run_instr(input logic [6:0] opc, input logic x17, input int force_bc);
    int L, k, exp_cyc, fr, irw, irw_at, dr, dw, rw;
    logic bc[48];
    logic taken, ld, st, jl, ar, wr;
    logic [14:0] o;
    L = sel ? 3 : 1;
    for (int i = 0; i < 48; i++)
      bc[i] = (force_bc == 1) ? 1'b1 : (force_bc == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    ld = (opc == T_LOAD);
    st = (opc == T_STORE);
    jl = (opc == T_JAL) || (opc == T_JALR);
    ar = (opc == T_R) || (opc == T_I);
    wr = ld || ar || jl;
    taken = (opc == T_BR) && bc[L+1];
    if (ld || st) exp_cyc = 2 * L + 3;
    else if (opc == T_BR) exp_cyc = taken ? L + 2 : L + 3;
    else if (opc == T_JAL || opc == T_SYS) exp_cyc = L + 2;
    else exp_cyc = L + 3;
    fr = 0; irw = 0; irw_at = -1; dr = 0; dw = 0; rw = 0;
    part_of_inst = opc;
    ecall_x17_is_10 = x17;
    o = '0;
    for (k = 0; k < 48; k++) begin
      bcond = bc[k];
      #1 o = cur;
      if (o[MR] && !o[IORD]) fr++;
      if (o[MR] && o[IORD]) dr++;
      if (o[MW]) dw++;
      if (o[IRW]) begin irw++; irw_at = k; end
      if (o[RW]) rw++;
      if (k == L) check("id_alu", 32'(o[5:1]), 32'(5'b0_10_00));
      if (k == L + 1 && ar) check("ex_alu", 32'(o[5:1]), {27'd0, 1'b1, (opc == T_R) ? 2'b00 : 2'b10, 2'b10});
      if (o[PCW]) break;
      @(negedge clk);
    end
    check("cycles", 32'(k + 1), 32'(exp_cyc));
    check("fetch_reads", 32'(fr), 32'(L));
    check("ir_write_cnt", 32'(irw), 32'd1);
    check("ir_write_at", 32'(irw_at), 32'(L - 1));
    check("data_reads", 32'(dr), ld ? 32'(L) : 32'd0);
    check("data_writes", 32'(dw), st ? 32'(L) : 32'd0);
    check("reg_write_cnt", 32'(rw), wr ? 32'd1 : 32'd0);
    check("pc_source", 32'(o[PCS]), 32'(jl || taken));
    check("mem_to_reg", 32'(o[M2R]), 32'(ld));
    check("pc_to_reg", 32'(o[P2R]), 32'(jl));
    check("final_alu", 32'(o[5:1]), taken ? 32'(5'b1_00_01) : 32'(5'b0_01_00));
    check("not_halted", 32'(o[H]), 32'd0);
    @(negedge clk);
  endtask

  // Store interrupted by reset during its memory phase; ends in fetch cycle 0.
  task automatic reset_in_mem();
    part_of_inst = T_STORE;
    ecall_x17_is_10 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      bcond = 1'($urandom_range(0, 1));
      #1;
      if (cur[MW]) break;
      @(negedge clk);
    end
    check("mem_reached", 32'(cur[MW]), 32'd1);
    set_reset(1'b1);
    #1 check("mem_write_in_rst", 32'(cur[MW]), 32'd0);
    check("rst_mid_strobes", 32'(cur[14:1]), 32'd0);
    @(negedge clk);
    #1 check("rst_mid_state", 32'(cur), 32'd0);
    set_reset(1'b0);
    #1 check("refetch", 32'({cur[MR], cur[IORD], cur[MW], cur[H]}), 32'(4'b1000));
  endtask

  task automatic halt_test();
`ifdef MULTI_CYCLE_ECALL_HALT_EN
    int L;
    L = sel ? 3 : 1;
    part_of_inst = T_SYS;
    ecall_x17_is_10 = 1'b1;
    for (int k = 0; k < L + 8; k++) begin
      bcond = 1'($urandom_range(0, 1));
      #1;
      if (k <= L) check("pre_halt", 32'(cur[H]), 32'd0);
      else check("halted", 32'(cur), 32'h1);
      @(negedge clk);
    end
    do_reset();
`else
    run_instr(T_SYS, 1'b1, 0);
`endif
  endtask

  initial begin
    logic x17r;
    sel = 1'b0;
    reset1 = 1'b1;
    reset3 = 1'b1;
    bcond = 1'b0;
    ecall_x17_is_10 = 1'b0;
    part_of_inst = 7'd0;
    repeat (2) @(negedge clk);
    for (int ph = 0; ph < 2; ph++) begin
      set_reset(1'b1);
      sel = (ph == 1);
      do_reset();
      run_instr(T_R, 1'b0, 0);
      run_instr(T_I, 1'b0, 0);
      run_instr(T_LOAD, 1'b0, 0);
      run_instr(T_STORE, 1'b0, 0);
      run_instr(T_BR, 1'b0, 1);
      run_instr(T_BR, 1'b0, 2);
      run_instr(T_JAL, 1'b0, 0);
      run_instr(T_JALR, 1'b0, 0);
      run_instr(T_SYS, 1'b0, 0);
      run_instr(T_LUI, 1'b0, 0);
      for (int i = 0; i < 30; i++) begin
`ifdef MULTI_CYCLE_ECALL_HALT_EN
        x17r = 1'b0;
`else
        x17r = 1'($urandom_range(0, 1));
`endif
        run_instr(pick($urandom_range(0, 8)), x17r, 0);
      end
      reset_in_mem();
      run_instr(T_R, 1'b0, 0);
      halt_test();
      run_instr(T_LOAD, 1'b0, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
